// File: rtl/pcpi_cop_dispatch_if.sv
// Signal bundle between the PicoRV32 PCPI port, the dispatcher and its two coprocessors.
// master = core + coprocessor side, slave = the dispatcher.
interface pcpi_cop_dispatch_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  logic        m_valid;
  logic        cx_valid;
  logic [31:0] cop_insn;
  logic [31:0] cop_rs1;
  logic [31:0] cop_rs2;

  logic        m_wr;
  logic        m_ready;
  logic [31:0] m_rd;
  logic        cx_wr;
  logic        cx_ready;
  logic [31:0] cx_rd;

  logic        timeout_err;

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    output m_valid, cx_valid, cop_insn, cop_rs1, cop_rs2,
    input  m_wr, m_ready, m_rd, cx_wr, cx_ready, cx_rd,
    output timeout_err
  );

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    input  m_valid, cx_valid, cop_insn, cop_rs1, cop_rs2,
    output m_wr, m_ready, m_rd, cx_wr, cx_ready, cx_rd,
    input  timeout_err
  );
endinterface

// File: rtl/pcpi_cop_dispatch.sv
// PCPI front-end: decodes M-extension / custom-0 requests, drives one coprocessor, returns a registered response.
// Optional BUSY watchdog enabled by defining PCPI_DISPATCH_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a claimed request; wait follows pcpi_valid&&hit combinationally
// BUSY  | selected unit's valid held until its ready (or the watchdog fires)
// RESP  | one-cycle pcpi_ready with the registered wr/rd
// COOL  | one cycle ignoring pcpi_valid while the core drops it
module pcpi_cop_dispatch #(
  parameter logic [6:0]  CX_OPCODE      = 7'b0001011,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  pcpi_cop_dispatch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, COOL} state_t;

  state_t      state, state_nxt;
  logic        sel;
  logic        capture;
  logic        resp_load;
  logic        hit_m, hit_cx, hit;
  logic        sel_ready, sel_wr;
  logic [31:0] sel_rd;
  logic [31:0] insn_q, rs1_q, rs2_q;
  logic        rsp_wr;
  logic [31:0] rsp_rd;
  logic        timeout_hit;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("pcpi_cop_dispatch: TIMEOUT_CYCLES must be in 2..255");
  end

  assign hit_m  = (bus.pcpi_insn[6:0] == 7'b0110011) && (bus.pcpi_insn[31:25] == 7'b0000001);
  assign hit_cx = (bus.pcpi_insn[6:0] == CX_OPCODE);
  assign hit    = hit_m | hit_cx;

  // Only the latched unit is listened to; the other one's strobes never reach the response.
  assign sel_ready = sel ? bus.cx_ready : bus.m_ready;
  assign sel_wr    = sel ? bus.cx_wr    : bus.m_wr;
  assign sel_rd    = sel ? bus.cx_rd    : bus.m_rd;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    resp_load = 1'b0;
    case (state)
      IDLE: begin
        if (bus.pcpi_valid && hit) begin
          capture   = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (sel_ready) begin
          resp_load = 1'b1;
          state_nxt = RESP;
        end else if (timeout_hit) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = COOL;
      COOL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sel    <= 1'b0;
      insn_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rsp_wr <= 1'b0;
      rsp_rd <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        sel    <= ~hit_m;
        insn_q <= bus.pcpi_insn;
        rs1_q  <= bus.pcpi_rs1;
        rs2_q  <= bus.pcpi_rs2;
      end
      // Response registers are non-zero only during RESP; a forced completion loads zeros.
      rsp_wr <= resp_load & sel_wr;
      rsp_rd <= resp_load ? sel_rd : '0;
    end
  end

`ifdef PCPI_DISPATCH_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt;
  logic       timeout_err_q;

  assign timeout_hit = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (capture) begin
        cnt <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 8'd1;
      end
      // A ready arriving on the last allowed cycle wins over the watchdog.
      if (state == BUSY && !sel_ready && timeout_hit) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.pcpi_ready = (state == RESP);
  assign bus.pcpi_wr    = rsp_wr;
  assign bus.pcpi_rd    = rsp_rd;
  assign bus.pcpi_wait  = ((state == IDLE) && bus.pcpi_valid && hit) || (state == BUSY) || (state == RESP);
  assign bus.m_valid    = (state == BUSY) && !sel;
  assign bus.cx_valid   = (state == BUSY) && sel;
  assign bus.cop_insn   = insn_q;
  assign bus.cop_rs1    = rs1_q;
  assign bus.cop_rs2    = rs2_q;

endmodule
